// File: rtl/ldmx_dma_event_framer.sv
// DMA inbound event framer: header beat plus packed 16-bit samples, buffered onto a 64-bit AXIS stream.
// Header and sample beats enter the FIFO at the trigger/4th-sample edge; FWFT output one cycle later.
// tReady stalls hold the FIFO head; triggers without room for a whole event are dropped and counted.

// Generic first-word-fall-through FIFO.
// Latency: a beat written at edge N is visible at N+1 when the FIFO was empty.
// Backpressure: wr_rdy low when full; head held while rd_rdy is low.
module ldmx_dma_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  output logic                     wr_rdy,
  output logic                     rd_vld,
  output logic [W-1:0]             rd_dat,
  input  logic                     rd_rdy,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign wr_rdy = (fill != (AW+1)'(DEPTH));
  assign rd_vld = (fill != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end
endmodule

// Event framer top.
// Latency: header written at the accepted trigger edge, data beat at the edge of each 4th sample.
// Backpressure: dmaIbSlave_tReady stalls the FIFO; busy reflects fill >= BUSY_THRESH one cycle late.
module ldmx_dma_event_framer #(
  parameter int         SAMPLES_PER_EVENT = 32,
  parameter int         FIFO_DEPTH        = 64,
  parameter int         BUSY_THRESH       = 48,
  parameter logic [7:0] TDEST_VAL         = 8'h00
) (
  input  logic        dmaClk,
  input  logic        dmaRstL,
  input  logic        enable,
  input  logic        trigger,
  input  logic [15:0] dIn,
  input  logic        dInValid,
  output logic        dmaIbMaster_tValid,
  output logic [63:0] dmaIbMaster_tData,
  output logic [7:0]  dmaIbMaster_tStrb,
  output logic [7:0]  dmaIbMaster_tKeep,
  output logic        dmaIbMaster_tLast,
  output logic [7:0]  dmaIbMaster_tDest,
  output logic [7:0]  dmaIbMaster_tId,
  output logic [63:0] dmaIbMaster_tUser,
  input  logic        dmaIbSlave_tReady,
  output logic        busy,
  output logic [31:0] evtCount,
  output logic [15:0] dropCount
);
  localparam int          BEATS     = SAMPLES_PER_EVENT / 4;
  localparam int          AW        = $clog2(FIFO_DEPTH);
  // Largest fill that still leaves room for the header plus every data beat of an event.
  localparam logic [AW:0] MAX_FILL  = (AW+1)'(FIFO_DEPTH - 1 - BEATS);
  localparam logic [15:0] LAST_BEAT = 16'(BEATS - 1);
  localparam logic [31:0] BUSY_LVL  = BUSY_THRESH;

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [31:0]  timestamp;
  logic [47:0]  pack;
  logic [1:0]   pack_cnt;
  logic [15:0]  beat_cnt;
  logic         last_beat;
  logic         push;
  logic [65:0]  push_dat;
  logic         trig_acc;
  logic         trig_drop;
  logic         fifo_wr_rdy;
  logic         fifo_vld;
  logic [65:0]  fifo_dat;
  logic [AW:0]  fill;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_dat  = '0;
    trig_acc  = 1'b0;
    trig_drop = 1'b0;
    last_beat = (beat_cnt == LAST_BEAT);
    case (state)
      IDLE: begin
        if (trigger && enable) begin
          if (fill <= MAX_FILL) begin
            push      = 1'b1;
            push_dat  = {evtCount, timestamp, 1'b0, 1'b1};
            trig_acc  = 1'b1;
            state_nxt = CAPTURE;
          end else begin
            trig_drop = 1'b1;
          end
        end
      end
      CAPTURE: begin
        trig_drop = trigger && enable;
        if (dInValid && (pack_cnt == 2'd3)) begin
          push     = 1'b1;
          push_dat = {dIn, pack, last_beat, 1'b0};
          if (last_beat) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dmaClk or negedge dmaRstL) begin
    if (!dmaRstL) begin
      state     <= IDLE;
      timestamp <= '0;
      evtCount  <= '0;
      dropCount <= '0;
      pack      <= '0;
      pack_cnt  <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timestamp <= timestamp + 32'd1;
      busy      <= (32'(fill) >= BUSY_LVL);
      if (trig_acc) evtCount <= evtCount + 32'd1;
      if (trig_drop && (dropCount != 16'hFFFF)) dropCount <= dropCount + 16'd1;
      if (trig_acc) begin
        pack_cnt <= '0;
        beat_cnt <= '0;
      end else if ((state == CAPTURE) && dInValid) begin
        pack_cnt <= pack_cnt + 2'd1;
        case (pack_cnt)
          2'd0:    pack[15:0]  <= dIn;
          2'd1:    pack[31:16] <= dIn;
          2'd2:    pack[47:32] <= dIn;
          default: beat_cnt    <= last_beat ? 16'd0 : beat_cnt + 16'd1;
        endcase
      end
    end
  end

  ldmx_dma_fifo #(
    .W     (66),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (dmaClk),
    .rst_n  (dmaRstL),
    .wr_vld (push && fifo_wr_rdy),
    .wr_dat (push_dat),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (fifo_vld),
    .rd_dat (fifo_dat),
    .rd_rdy (dmaIbSlave_tReady),
    .fill   (fill)
  );

  // Gate the stream fields so nothing but zeros leaves the block while no beat is presented.
  assign dmaIbMaster_tValid = fifo_vld;
  assign dmaIbMaster_tData  = fifo_vld ? fifo_dat[65:2] : 64'd0;
  assign dmaIbMaster_tLast  = fifo_vld & fifo_dat[1];
  assign dmaIbMaster_tUser  = {62'd0, fifo_vld & fifo_dat[0], 1'b0};
  assign dmaIbMaster_tStrb  = fifo_vld ? 8'hFF : 8'h00;
  assign dmaIbMaster_tKeep  = fifo_vld ? 8'hFF : 8'h00;
  assign dmaIbMaster_tDest  = TDEST_VAL;
  assign dmaIbMaster_tId    = 8'h00;
endmodule
